// File: rtl/sprite_engine.sv
// Per-scanline sprite compositor: scans the attribute table from lowest to highest
// priority and overlays opaque sprite pixels onto the draw line buffer.
module sprite_engine #(
  parameter int NUM_SPRITES = 32,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int H_VISIBLE   = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sprite_start,
  input  logic [9:0]  draw_line,
  output logic        sprite_done,
  output logic        busy,
  input  logic        attr_we,
  input  logic [4:0]  attr_addr,
  input  logic [31:0] attr_wdata,
  output logic [13:0] rom_addr,
  input  logic [15:0] rom_q,
  output logic [9:0]  addr_pixel_draw,
  output logic [15:0] data_pixel_draw,
  output logic        wren_pixel_draw
);

  localparam int IDX_W = $clog2(NUM_SPRITES);
  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_SPRITES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(SPRITE_W - 1);
  localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
  localparam logic [9:0]       ROW_LIMIT = 10'(SPRITE_H);
  localparam logic [10:0]      X_LIMIT   = 11'(H_VISIBLE);

  typedef enum logic [2:0] {IDLE, EVAL, FETCH, FLUSH, DONE} state_t;

  typedef struct packed {
    logic       hflip;
    logic [5:0] frame;
    logic [9:0] x;
    logic [8:0] y;
  } attr_t;

  state_t state, state_nxt;

  logic  attr_en   [NUM_SPRITES];
  attr_t attr_body [NUM_SPRITES];

  logic [9:0]       line_q;
  logic [IDX_W-1:0] idx;
  logic [5:0]       frame_q;
  logic             hflip_q;
  logic [9:0]       x_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_d;
  logic             wr_valid;

  attr_t       cur;
  logic        cur_en;
  logic [9:0]  row_full;
  logic        visible;
  logic [10:0] px;
  logic        unused_reserved;

  // Reserved attribute bits carry no meaning and are dropped on write.
  assign unused_reserved = ^attr_wdata[4:0];

  // Attribute table
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) attr_en[i] <= 1'b0;
    end else if (attr_we) begin
      attr_en[attr_addr] <= attr_wdata[31];
    end
  end

  // NOTE: only the enable bits are reset; the other fields are ignored while a
  // sprite is disabled, so they stay plain storage without a reset network.
  always_ff @(posedge clk) begin
    if (attr_we) attr_body[attr_addr] <= attr_t'(attr_wdata[30:5]);
  end

  // Candidate evaluation: a 10-bit wrap makes sprites below the line look far away.
  assign cur      = attr_body[idx];
  assign cur_en   = attr_en[idx];
  assign row_full = line_q - {1'b0, cur.y};
  assign visible  = cur_en && (row_full < ROW_LIMIT);

  // NOTE: every sequential process uses non-blocking assignments so all
  // registers update together from the values present before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    sprite_done = (state == DONE);
    rom_addr    = '0;
    unique case (state)
      IDLE:  if (sprite_start) state_nxt = EVAL;
      EVAL: begin
        if (visible)         state_nxt = FETCH;
        else if (idx == '0)  state_nxt = FLUSH;
      end
      FETCH: begin
        rom_addr = {frame_q, row_q, (hflip_q ? ~col : col)};
        if (col == COL_LAST) state_nxt = (idx == '0) ? FLUSH : EVAL;
      end
      FLUSH: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q   <= '0;
      idx      <= '0;
      frame_q  <= '0;
      hflip_q  <= 1'b0;
      x_q      <= '0;
      row_q    <= '0;
      col      <= '0;
      col_d    <= '0;
      wr_valid <= 1'b0;
    end else begin
      wr_valid <= (state == FETCH);
      col_d    <= col;
      unique case (state)
        IDLE: begin
          if (sprite_start) begin
            line_q <= draw_line;
            idx    <= IDX_LAST;
          end
        end
        EVAL: begin
          if (visible) begin
            frame_q <= cur.frame;
            hflip_q <= cur.hflip;
            x_q     <= cur.x;
            row_q   <= row_full[ROW_W-1:0];
            col     <= '0;
          end else if (idx != '0) begin
            idx <= idx - IDX_ONE;
          end
        end
        FETCH: begin
          col <= col + COL_ONE;
          if (col == COL_LAST && idx != '0) idx <= idx - IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  // Write stage trails the fetch by one cycle, matching the ROM read latency;
  // x_q only changes at the end of an EVAL, after this write has used it.
  assign px              = {1'b0, x_q} + {{(11-COL_W){1'b0}}, col_d};
  assign wren_pixel_draw = wr_valid && rom_q[0] && (px < X_LIMIT);
  assign addr_pixel_draw = wr_valid ? px[9:0] : '0;
  assign data_pixel_draw = wr_valid ? rom_q : '0;

endmodule

// File: tb/tb_sprite_engine.sv
// Randomized and directed bench for sprite_engine against a line-level model
// that walks the attribute table in priority order and paints a line buffer.
module tb_sprite_engine;

  localparam int WIN   = 560;
  localparam int H_VIS = 640;

  logic        clk = 1'b0;
  logic        reset;
  logic        sprite_start;
  logic [9:0]  draw_line;
  logic        sprite_done;
  logic        busy;
  logic        attr_we;
  logic [4:0]  attr_addr;
  logic [31:0] attr_wdata;
  logic [13:0] rom_addr;
  logic [15:0] rom_q;
  logic [9:0]  addr_pixel_draw;
  logic [15:0] data_pixel_draw;
  logic        wren_pixel_draw;

  sprite_engine dut (
    .clk             (clk),
    .reset           (reset),
    .sprite_start    (sprite_start),
    .draw_line       (draw_line),
    .sprite_done     (sprite_done),
    .busy            (busy),
    .attr_we         (attr_we),
    .attr_addr       (attr_addr),
    .attr_wdata      (attr_wdata),
    .rom_addr        (rom_addr),
    .rom_q           (rom_q),
    .addr_pixel_draw (addr_pixel_draw),
    .data_pixel_draw (data_pixel_draw),
    .wren_pixel_draw (wren_pixel_draw)
  );

  always #10 clk = ~clk;

  logic [15:0] rom_mem [16384];
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  int vectors = 0;
  int errors  = 0;

  logic [31:0] tbl [32];
  logic [15:0] exp_buf [H_VIS];
  logic [15:0] dut_buf [H_VIS];
  bit          exp_busy  [WIN];
  bit          exp_done  [WIN];
  bit          exp_wr    [WIN];
  bit          exp_fetch [WIN];
  int          exp_rom   [WIN];
  int          exp_addr  [WIN];
  logic [15:0] exp_data  [WIN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_attr(bit en, bit hf, int fr, int x, int y);
    return {en, hf, 6'(fr), 10'(x), 9'(y), 5'b0};
  endfunction

  function automatic logic [15:0] tile(int i);
    return 16'(i * 7 + 16'h1234);
  endfunction

  task automatic fill_opaque();
    for (int a = 0; a < 16384; a++) rom_mem[a] = {1'b0, 14'(a), 1'b1};
  endtask

  task automatic fill_random();
    logic [31:0] r;
    for (int a = 0; a < 16384; a++) begin
      r = $urandom;
      r[0] = ($urandom_range(0, 3) != 0);
      rom_mem[a] = r[15:0];
    end
  endtask

  task automatic write_attr(input int a, input logic [31:0] d);
    @(negedge clk);
    attr_we    = 1'b1;
    attr_addr  = 5'(a);
    attr_wdata = d;
    @(negedge clk);
    attr_we = 1'b0;
    tbl[a] = d;
  endtask

  task automatic clear_table();
    for (int s = 0; s < 32; s++) write_attr(s, 32'h0);
  endtask

  // Line model: walk sprites 31..0, one evaluation slot each plus 16 fetch slots
  // when visible; pixels land one slot after their fetch and later ones win.
  task automatic build_expect(input logic [9:0] line);
    int t, r, rc, a, px, done_k;
    logic [31:0] e;
    logic [15:0] d;
    for (int k = 0; k < WIN; k++) begin
      exp_busy[k] = 0; exp_done[k] = 0; exp_wr[k] = 0; exp_fetch[k] = 0;
      exp_rom[k] = 0; exp_addr[k] = 0; exp_data[k] = '0;
    end
    for (int i = 0; i < H_VIS; i++) exp_buf[i] = tile(i);
    t = 1;
    for (int s = 31; s >= 0; s--) begin
      e = tbl[s];
      r = int'(line) - int'(e[13:5]);
      if (r < 0) r += 1024;
      t++;
      if (e[31] && r < 16) begin
        for (int c = 0; c < 16; c++) begin
          rc = e[30] ? 15 - c : c;
          a  = int'(e[29:24]) * 256 + r * 16 + rc;
          d  = rom_mem[a];
          px = int'(e[23:14]) + c;
          exp_fetch[t] = 1;
          exp_rom[t]   = a;
          if (d[0] && px < H_VIS) begin
            exp_wr[t+1]   = 1;
            exp_addr[t+1] = px;
            exp_data[t+1] = d;
            exp_buf[px]   = d;
          end
          t++;
        end
      end
    end
    done_k = t + 1;
    for (int k = 1; k <= done_k; k++) exp_busy[k] = 1;
    exp_done[done_k] = 1;
  endtask

  task automatic run_line(input logic [9:0] line, input bit coin, input int coin_a,
                          input logic [31:0] coin_d, input bit mid, input logic [31:0] mid_d);
    @(negedge clk);
    sprite_start = 1'b1;
    draw_line    = line;
    if (coin) begin
      attr_we    = 1'b1;
      attr_addr  = 5'(coin_a);
      attr_wdata = coin_d;
      tbl[coin_a] = coin_d;
    end
    build_expect(line);
    for (int i = 0; i < H_VIS; i++) dut_buf[i] = tile(i);
    check($sformatf("busy@0 line %0d", line), busy, 0);
    for (int k = 1; k < WIN; k++) begin
      @(negedge clk);
      if (k == 1) begin
        sprite_start = 1'b0;
        attr_we      = 1'b0;
      end
      if (mid && k == 3) begin
        attr_we    = 1'b1;
        attr_addr  = 5'd31;
        attr_wdata = mid_d;
      end
      if (mid && k == 4) attr_we = 1'b0;
      check($sformatf("busy@%0d", k), busy, exp_busy[k]);
      check($sformatf("done@%0d", k), sprite_done, exp_done[k]);
      check($sformatf("wren@%0d", k), wren_pixel_draw, exp_wr[k]);
      if (exp_wr[k]) begin
        check($sformatf("addr@%0d", k), addr_pixel_draw, exp_addr[k]);
        check($sformatf("data@%0d", k), data_pixel_draw, exp_data[k]);
      end
      if (exp_fetch[k]) check($sformatf("rom_addr@%0d", k), rom_addr, exp_rom[k]);
      if (wren_pixel_draw && addr_pixel_draw < 10'(H_VIS)) dut_buf[addr_pixel_draw] = data_pixel_draw;
    end
    if (mid) tbl[31] = mid_d;
    for (int i = 0; i < H_VIS; i++) check($sformatf("pixel %0d line %0d", i, line), dut_buf[i], exp_buf[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, sprite_done, 0);
    check({tag, " wren"}, wren_pixel_draw, 0);
    check({tag, " rom_addr"}, rom_addr, 0);
    check({tag, " addr"}, addr_pixel_draw, 0);
    check({tag, " data"}, data_pixel_draw, 0);
  endtask

  initial begin
    logic [9:0] line;
    int off;
    reset = 1'b1; sprite_start = 1'b0; draw_line = '0;
    attr_we = 1'b0; attr_addr = '0; attr_wdata = '0; rom_q = '0;
    for (int s = 0; s < 32; s++) tbl[s] = 32'h0;
    fill_opaque();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // No sprites enabled: done at +34 and no writes.
    run_line(10'd100, 0, 0, 0, 0, 0);

    // Single sprite, then mirrored.
    write_attr(0, mk_attr(1, 0, 2, 40, 95));
    run_line(10'd100, 0, 0, 0, 0, 0);
    write_attr(0, mk_attr(1, 1, 2, 40, 95));
    run_line(10'd100, 0, 0, 0, 0, 0);

    // Overlap: sprite 0 must win over sprite 5.
    write_attr(0, mk_attr(1, 0, 1, 100, 100));
    write_attr(5, mk_attr(1, 0, 3, 100, 100));
    run_line(10'd100, 0, 0, 0, 0, 0);

    // Right-edge clipping with two transparent columns.
    clear_table();
    write_attr(0, mk_attr(1, 0, 4, 630, 100));
    rom_mem[4*256 + 2][0] = 1'b0;
    rom_mem[4*256 + 3][0] = 1'b0;
    run_line(10'd100, 0, 0, 0, 0, 0);

    // Row 15 at frame 63, a sprite just below the line, a disabled one.
    clear_table();
    fill_opaque();
    write_attr(1, mk_attr(1, 0, 63, 200, 85));
    write_attr(2, mk_attr(1, 0, 7, 300, 101));
    write_attr(3, mk_attr(0, 0, 9, 400, 100));
    run_line(10'd100, 0, 0, 0, 0, 0);

    // Start coincident with an attribute write that makes entry 7 visible.
    run_line(10'd100, 1, 7, mk_attr(1, 1, 5, 10, 100), 0, 0);

    // Reset during FETCH aborts the line; a later start works normally.
    clear_table();
    write_attr(0, mk_attr(1, 0, 2, 40, 95));
    @(negedge clk);
    sprite_start = 1'b1;
    draw_line    = 10'd100;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) sprite_start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_idle_outputs("midline reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("held reset done %0d", k), sprite_done, 0);
      check($sformatf("held reset wren %0d", k), wren_pixel_draw, 0);
    end
    reset = 1'b0;
    for (int s = 0; s < 32; s++) tbl[s][31] = 1'b0;
    run_line(10'd100, 0, 0, 0, 0, 0);
    write_attr(0, mk_attr(1, 0, 2, 40, 95));
    run_line(10'd100, 0, 0, 0, 0, 0);

    // Randomized lines with coincident and mid-scan table writes.
    fill_random();
    for (int n = 0; n < 12; n++) begin
      line = 10'($urandom_range(0, 524));
      for (int s = 0; s < 32; s++) begin
        off = $urandom_range(0, 24);
        write_attr(s, mk_attr($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                              $urandom_range(0, 63), $urandom_range(0, 700), int'(line) - off));
      end
      off = $urandom_range(0, 15);
      run_line(line, (n % 3) == 0, $urandom_range(0, 31),
               mk_attr(1, $urandom_range(0, 1) == 1, $urandom_range(0, 63),
                       $urandom_range(0, 700), int'(line) - off),
               (n % 4) == 1,
               mk_attr($urandom_range(0, 1) == 1, 0, $urandom_range(0, 63),
                       $urandom_range(0, 700), int'(line) - off));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
